// File: rtl/knn_scheduler.sv
// Sequencer for a k-NN classifier: walks every test point against every data point,
// handshaking with the distance unit, the neighbour-list inserter and the label voter.
//   state | meaning
//   IDLE  | waiting for start
//   CLR   | clear neighbour list for current test point
//   REQ   | request distance, hold until dist_ack
//   WAIT  | wait for dist_valid
//   INS   | request neighbour insert, hold until ins_done
//   NEXT  | advance data index or move to vote
//   VOTE  | request label vote, hold until vote_done
//   DONE  | one-cycle completion pulse
module knn_scheduler #(
    parameter int DATA_W = 8,
    parameter int TEST_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [DATA_W-1:0] n_data,
    input  logic [TEST_W-1:0] n_test,
    input  logic              dist_ack,
    input  logic              dist_valid,
    input  logic              ins_done,
    input  logic              vote_done,
    output logic              busy,
    output logic              done,
    output logic              nb_clr,
    output logic              dist_req,
    output logic              ins_req,
    output logic              vote_req,
    output logic [DATA_W-1:0] data_idx,
    output logic [TEST_W-1:0] test_idx
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] CLR  = 3'd1;
    localparam logic [2:0] REQ  = 3'd2;
    localparam logic [2:0] WAIT = 3'd3;
    localparam logic [2:0] INS  = 3'd4;
    localparam logic [2:0] NEXT = 3'd5;
    localparam logic [2:0] VOTE = 3'd6;
    localparam logic [2:0] DONE = 3'd7;

    logic [2:0]        state;
    logic [DATA_W-1:0] n_data_q;
    logic [TEST_W-1:0] n_test_q;

    // Counts are nonzero whenever the last-index compares are reached, so no wrap on -1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            data_idx <= '0;
            test_idx <= '0;
            n_data_q <= '0;
            n_test_q <= '0;
        end else if (abort && state != IDLE) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (n_data != '0 && n_test != '0) begin
                            n_data_q <= n_data;
                            n_test_q <= n_test;
                            data_idx <= '0;
                            test_idx <= '0;
                            state    <= CLR;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                CLR:  state <= REQ;
                REQ:  if (dist_ack)   state <= WAIT;
                WAIT: if (dist_valid) state <= INS;
                INS:  if (ins_done)   state <= NEXT;
                NEXT: begin
                    if (data_idx == n_data_q - DATA_W'(1)) begin
                        state <= VOTE;
                    end else begin
                        data_idx <= data_idx + DATA_W'(1);
                        state    <= REQ;
                    end
                end
                VOTE: begin
                    if (vote_done) begin
                        if (test_idx == n_test_q - TEST_W'(1)) begin
                            state <= DONE;
                        end else begin
                            test_idx <= test_idx + TEST_W'(1);
                            data_idx <= '0;
                            state    <= CLR;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state != IDLE);
    assign done     = (state == DONE);
    assign nb_clr   = (state == CLR);
    assign dist_req = (state == REQ);
    assign ins_req  = (state == INS);
    assign vote_req = (state == VOTE);

endmodule

// File: tb/tb_knn_scheduler.sv
// Scoreboard bench for knn_scheduler: stimulus queues expected handshake events,
// a monitor pops and compares them as the scheduler raises its outputs.
module tb_knn_scheduler;

    localparam int DATA_W = 8;
    localparam int TEST_W = 4;

    localparam logic [2:0] EV_CLR  = 3'd1;
    localparam logic [2:0] EV_DIST = 3'd2;
    localparam logic [2:0] EV_INS  = 3'd3;
    localparam logic [2:0] EV_VOTE = 3'd4;
    localparam logic [2:0] EV_DONE = 3'd5;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              abort;
    logic [DATA_W-1:0] n_data;
    logic [TEST_W-1:0] n_test;
    logic              dist_ack;
    logic              dist_valid;
    logic              ins_done;
    logic              vote_done;
    logic              busy;
    logic              done;
    logic              nb_clr;
    logic              dist_req;
    logic              ins_req;
    logic              vote_req;
    logic [DATA_W-1:0] data_idx;
    logic [TEST_W-1:0] test_idx;

    int checks = 0;
    int errors = 0;
    int ack_dly = 1;
    int val_dly = 1;
    logic [14:0] exp_q[$];

    knn_scheduler #(.DATA_W(DATA_W), .TEST_W(TEST_W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .n_data(n_data), .n_test(n_test),
        .dist_ack(dist_ack), .dist_valid(dist_valid),
        .ins_done(ins_done), .vote_done(vote_done),
        .busy(busy), .done(done), .nb_clr(nb_clr),
        .dist_req(dist_req), .ins_req(ins_req), .vote_req(vote_req),
        .data_idx(data_idx), .test_idx(test_idx)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] ev(input logic [2:0] t, input int ti, input int di);
        return {t, 4'(ti), 8'(di)};
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic sb(input string name, input logic [14:0] got);
        logic [14:0] want;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: unexpected event got %h, nothing expected at %0t", name, got, $time);
        end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
                errors++;
                $display("FAIL %s: got %h expected %h at %0t", name, got, want, $time);
            end
        end
    endtask

    task automatic push_batch(input int nd, input int nt);
        for (int t = 0; t < nt; t++) begin
            exp_q.push_back(ev(EV_CLR, t, 0));
            for (int d = 0; d < nd; d++) begin
                exp_q.push_back(ev(EV_DIST, t, d));
                exp_q.push_back(ev(EV_INS, t, d));
            end
            exp_q.push_back(ev(EV_VOTE, t, nd - 1));
        end
        exp_q.push_back(ev(EV_DONE, nt - 1, nd - 1));
    endtask

    task automatic run_start(input int nd, input int nt);
        @(negedge clk);
        n_data = DATA_W'(nd);
        n_test = TEST_W'(nt);
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk({name, "_done_seen"}, int'(done), 1);
        repeat (2) @(posedge clk);
        #1;
        chk({name, "_queue_empty"}, exp_q.size(), 0);
    endtask

    // Responders: distance unit with programmable ack/valid delays, single-cycle inserter and voter.
    initial begin
        int req_cnt = 0;
        int val_cnt = 0;
        bit val_pend = 1'b0;
        dist_ack = 1'b0; dist_valid = 1'b0; ins_done = 1'b0; vote_done = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                req_cnt = 0; val_cnt = 0; val_pend = 1'b0;
                dist_ack = 1'b0; dist_valid = 1'b0; ins_done = 1'b0; vote_done = 1'b0;
            end else begin
                dist_valid = 1'b0;
                if (val_pend && !dist_req) begin
                    val_cnt++;
                    if (val_cnt >= val_dly) begin
                        dist_valid = 1'b1;
                        val_pend   = 1'b0;
                    end
                end
                if (dist_req) begin
                    req_cnt++;
                    dist_ack = (req_cnt >= ack_dly);
                    if (dist_ack) begin
                        val_pend = 1'b1;
                        val_cnt  = 0;
                    end
                end else begin
                    req_cnt  = 0;
                    dist_ack = 1'b0;
                end
                ins_done  = ins_req;
                vote_done = vote_req;
            end
        end
    end

    // Monitor: every rising request/pulse is one scoreboard event.
    initial begin
        logic p_clr = 1'b0, p_dreq = 1'b0, p_ins = 1'b0, p_vote = 1'b0, p_done = 1'b0;
        int len = 0;
        bit vseen = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                p_clr = 1'b0; p_dreq = 1'b0; p_ins = 1'b0; p_vote = 1'b0; p_done = 1'b0;
                len = 0; vseen = 1'b0;
            end else begin
                if (dist_valid) vseen = 1'b1;
                if (nb_clr && !p_clr) sb("nb_clr_event", ev(EV_CLR, int'(test_idx), int'(data_idx)));
                if (dist_req && !p_dreq) begin
                    sb("dist_req_event", ev(EV_DIST, int'(test_idx), int'(data_idx)));
                    len = 0;
                end
                if (dist_req) len++;
                if (!dist_req && p_dreq) chk("dist_req_hold_cycles", len, ack_dly);
                if (ins_req && !p_ins) begin
                    sb("ins_req_event", ev(EV_INS, int'(test_idx), int'(data_idx)));
                    chk("dist_valid_before_ins", int'(vseen), 1);
                    vseen = 1'b0;
                end
                if (vote_req && !p_vote) sb("vote_req_event", ev(EV_VOTE, int'(test_idx), int'(data_idx)));
                if (done && !p_done) sb("done_event", ev(EV_DONE, int'(test_idx), int'(data_idx)));
                p_clr = nb_clr; p_dreq = dist_req; p_ins = ins_req; p_vote = vote_req; p_done = done;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish at %0t", $time);
        $fatal(1);
    end

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; abort = 1'b0; n_data = '0; n_test = '0;
        #12;
        chk("reset_ctrl_outputs", int'({busy, done, nb_clr, dist_req, ins_req, vote_req}), 0);
        chk("reset_data_idx", int'(data_idx), 0);
        chk("reset_test_idx", int'(test_idx), 0);
        @(negedge clk);
        rst = 1'b0;

        // Batch A: 3 data x 2 test, prompt responders, start-to-dist_req latency.
        push_batch(3, 2);
        @(negedge clk);
        n_data = 8'd3; n_test = 4'd2; start = 1'b1;
        @(posedge clk); #1;
        chk("latency_nb_clr_cycle1", int'(nb_clr), 1);
        @(posedge clk); #1;
        chk("latency_dist_req_cycle2", int'(dist_req), 1);
        start = 1'b0;
        wait_done("batch_a", 200);

        // Batch B: slow distance unit, plus a start with a new n_data while busy.
        ack_dly = 5; val_dly = 4;
        push_batch(2, 1);
        run_start(2, 1);
        repeat (3) @(negedge clk);
        n_data = 8'd5; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("batch_b", 300);
        ack_dly = 1; val_dly = 1;

        // Abort in INS at data_idx=1, then a clean batch.
        exp_q.push_back(ev(EV_CLR, 0, 0));
        exp_q.push_back(ev(EV_DIST, 0, 0));
        exp_q.push_back(ev(EV_INS, 0, 0));
        exp_q.push_back(ev(EV_DIST, 0, 1));
        exp_q.push_back(ev(EV_INS, 0, 1));
        run_start(3, 2);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ins_req && data_idx == 8'd1) && n < 200);
        chk("abort_reach_ins_idx1", int'(ins_req && data_idx == 8'd1), 1);
        abort = 1'b1;
        @(posedge clk); #1;
        chk("abort_busy_low", int'(busy), 0);
        chk("abort_ins_req_low", int'(ins_req), 0);
        chk("abort_no_done", int'(done), 0);
        @(negedge clk);
        abort = 1'b0;
        chk("abort_queue_empty", exp_q.size(), 0);
        push_batch(2, 2);
        run_start(2, 2);
        wait_done("after_abort", 200);

        // Asynchronous reset during WAIT, then an immediate zero-count start.
        val_dly = 4;
        exp_q.push_back(ev(EV_CLR, 0, 0));
        exp_q.push_back(ev(EV_DIST, 0, 0));
        run_start(4, 1);
        n = 0;
        while (!dist_req && n < 50) begin @(negedge clk); n++; end
        while (dist_req && n < 100) begin @(negedge clk); n++; end
        chk("rst_test_in_wait_busy", int'(busy && !dist_req && !ins_req), 1);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_ctrl_outputs", int'({busy, done, nb_clr, dist_req, ins_req, vote_req}), 0);
        chk("async_rst_data_idx", int'(data_idx), 0);
        chk("async_rst_test_idx", int'(test_idx), 0);
        @(negedge clk);
        #2;
        chk("rst_queue_empty", exp_q.size(), 0);
        val_dly = 1;
        exp_q.push_back(ev(EV_DONE, 0, 0));
        rst = 1'b0;
        n_data = 8'd0; n_test = 4'd4; start = 1'b1;
        @(posedge clk); #1;
        chk("zero_count_done_pulse", int'(done), 1);
        start = 1'b0;
        @(posedge clk); #1;
        chk("zero_count_done_one_cycle", int'(done), 0);
        chk("zero_count_idle", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
        chk("zero_count_queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
